dcache_dm_wb: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache.
- Responder on the pipeline's D-cache interface: takes ren/wen/addr/wdata, returns stall/rdata.
- Initiator on a 128-bit block-wide memory interface with a ready handshake.
- Sits between the pipeline MEM stage and slow main memory.

---
 rtl/dcache_dm_wb.sv | 163 ++++++++++++++++
 tb/tb_dcache_dm_wb.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_dm_wb.sv
// Direct-mapped, write-back, write-allocate data cache between the pipeline MEM
// stage and a 128-bit block memory that completes each request with a ready pulse.
module dcache_dm_wb #(
  parameter int unsigned INDEX_W = 3,
  parameter int unsigned TAG_W   = 25
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic         proc_stall,
  output logic [31:0]  proc_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  localparam int unsigned NUM_BLOCKS = 2 ** INDEX_W;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned LINE_W     = 128;
  localparam int unsigned BADDR_W    = 28;

  typedef enum logic [1:0] {
    S_COMPARE   = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_BLOCKS-1:0]   valid_q, valid_d;
  logic [NUM_BLOCKS-1:0]   dirty_q, dirty_d;
  logic [TAG_W-1:0]        tag_q  [NUM_BLOCKS];
  logic [TAG_W-1:0]        tag_d  [NUM_BLOCKS];
  logic [LINE_W-1:0]       data_q [NUM_BLOCKS];
  logic [LINE_W-1:0]       data_d [NUM_BLOCKS];
  logic                    mem_read_q, mem_read_d;
  logic                    mem_write_q, mem_write_d;
  logic [BADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]       mem_wdata_q, mem_wdata_d;

  logic [TAG_W-1:0]        addr_tag;
  logic [INDEX_W-1:0]      idx;
  logic [1:0]              off;
  logic [6:0]              bit_off;
  logic                    req;
  logic                    hit;
  logic [LINE_W-1:0]       merged;

  // Address split: word offset, line index, tag.
  assign addr_tag = proc_addr[INDEX_W+2 +: TAG_W];
  assign idx      = proc_addr[2 +: INDEX_W];
  assign off      = proc_addr[1:0];
  assign bit_off  = {off, 5'b0};
  assign req      = proc_read | proc_write;
  assign hit      = req & valid_q[idx] & (tag_q[idx] == addr_tag);

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Next-state, array updates and the combinational processor response.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    tag_d       = tag_q;
    data_d      = data_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    proc_stall  = 1'b0;
    proc_rdata  = '0;
    merged      = data_q[idx];
    merged[bit_off +: WORD_W] = proc_wdata;

    case (state_q)
      S_COMPARE: begin
        proc_stall = req & ~hit;
        if (proc_read & hit) begin
          proc_rdata = data_q[idx][bit_off +: WORD_W];
        end
        if (proc_write & hit) begin
          data_d[idx]  = merged;
          dirty_d[idx] = 1'b1;
        end else if (req & ~hit) begin
          if (valid_q[idx] & dirty_q[idx]) begin
            state_d     = S_WRITEBACK;
            mem_write_d = 1'b1;
            mem_addr_d  = BADDR_W'({tag_q[idx], idx});
            mem_wdata_d = data_q[idx];
          end else begin
            state_d    = S_ALLOCATE;
            mem_read_d = 1'b1;
            mem_addr_d = BADDR_W'({addr_tag, idx});
          end
        end
      end
      S_WRITEBACK: begin
        proc_stall = 1'b1;
        if (mem_ready) begin
          state_d     = S_ALLOCATE;
          mem_write_d = 1'b0;
          mem_read_d  = 1'b1;
          mem_addr_d  = BADDR_W'({addr_tag, idx});
        end
      end
      S_ALLOCATE: begin
        proc_stall = 1'b1;
        if (mem_ready) begin
          state_d      = S_COMPARE;
          mem_read_d   = 1'b0;
          data_d[idx]  = mem_rdata;
          tag_d[idx]   = addr_tag;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
        end
      end
      default: begin
        state_d = S_COMPARE;
      end
    endcase

    // Processor sees a quiet cache while reset is held.
    if (!rst_n) begin
      proc_stall = 1'b0;
      proc_rdata = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_COMPARE;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Tag and data arrays carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_dcache_dm_wb.sv
// Scoreboard bench for dcache_dm_wb: a transaction-level cache/memory model
// predicts load data, stall counts and memory traffic; monitors compare.
module tb_dcache_dm_wb;

  localparam int unsigned NB = 8;

  logic         clk;
  logic         rst_n;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  dcache_dm_wb #(.INDEX_W(3), .TAG_W(25)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { bit rd; logic [31:0] rdata; int lat; } exp_t;
  typedef struct { bit wr; logic [27:0] addr; logic [127:0] wdata; } mexp_t;

  exp_t  exp_q[$];
  mexp_t mem_q[$];
  int    total = 0;
  int    bad   = 0;
  int    mem_lat = 3;
  int    lat_cnt = 0;

  // Reference cache contents and the two memory images (model view, physical).
  bit           m_valid [NB];
  bit           m_dirty [NB];
  logic [24:0]  m_tag   [NB];
  logic [127:0] m_data  [NB];
  logic [127:0] ref_mem  [bit [27:0]];
  logic [127:0] phys_mem [bit [27:0]];

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [127:0] blk_init(input bit [27:0] a);
    return {4'h3, a, 4'h2, a, 4'h1, a, 4'h0, a};
  endfunction

  function automatic logic [127:0] mem_get(input bit phys, input bit [27:0] a);
    if (phys) return phys_mem.exists(a) ? phys_mem[a] : blk_init(a);
    return ref_mem.exists(a) ? ref_mem[a] : blk_init(a);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endfunction

  // One processor access at transaction level: eviction, fill, then the word op.
  function automatic void model_access(input bit wr, input bit rd, input logic [29:0] a,
                                       input logic [31:0] wd);
    int          ix  = int'(a[4:2]);
    int          off = int'(a[1:0]);
    logic [24:0] tg  = a[29:5];
    exp_t        e;
    mexp_t       m;
    e.rd = rd && !wr;
    e.lat = 0;
    if (!(m_valid[ix] && m_tag[ix] == tg)) begin
      if (m_valid[ix] && m_dirty[ix]) begin
        m.wr = 1'b1; m.addr = {m_tag[ix], a[4:2]}; m.wdata = m_data[ix];
        mem_q.push_back(m);
        ref_mem[m.addr] = m_data[ix];
        e.lat += mem_lat;
      end
      m.wr = 1'b0; m.addr = a[29:2]; m.wdata = '0;
      mem_q.push_back(m);
      m_data[ix]  = mem_get(1'b0, a[29:2]);
      m_tag[ix]   = tg;
      m_valid[ix] = 1'b1;
      m_dirty[ix] = 1'b0;
      e.lat += 1 + mem_lat;
    end
    if (wr) begin
      m_data[ix][32*off +: 32] = wd;
      m_dirty[ix] = 1'b1;
    end
    e.rdata = m_data[ix][32*off +: 32];
    exp_q.push_back(e);
  endfunction

  task automatic access(input bit wr, input bit rd, input logic [29:0] a, input logic [31:0] wd);
    int n = 0;
    model_access(wr, rd, a, wd);
    proc_addr = a; proc_wdata = wd; proc_write = wr; proc_read = rd;
    @(negedge clk);
    while (proc_stall && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (proc_stall) begin
      total++; bad++;
      $display("FAIL access_timeout addr=%0h still stalled", a);
    end
    @(posedge clk); #1;
    proc_read = 1'b0; proc_write = 1'b0;
  endtask

  // Read miss interrupted by reset while the fill is outstanding.
  task automatic reset_mid(input logic [29:0] a);
    int n = 0;
    mem_lat = 10;
    model_access(1'b0, 1'b1, a, '0);
    proc_addr = a; proc_read = 1'b1;
    @(negedge clk);
    while (!mem_read && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rm_fill_started", 128'(mem_read), 128'(1));
    @(negedge clk); @(posedge clk); #2;
    rst_n = 1'b0; #1;
    chk("rm_mem_read", 128'(mem_read), '0);
    chk("rm_mem_addr", 128'(mem_addr), '0);
    chk("rm_stall", 128'(proc_stall), '0);
    chk("rm_rdata", 128'(proc_rdata), '0);
    proc_read = 1'b0;
    exp_q.delete();
    mem_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Processor-side monitor: stall count and load data per completed request.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        lat_cnt = 0;
      end else if (proc_read || proc_write) begin
        if (proc_stall) begin
          lat_cnt++;
          chk("stall_rdata", 128'(proc_rdata), '0);
        end else if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL proc_unexpected completion addr=%0h", proc_addr);
        end else begin
          e = exp_q.pop_front();
          chk("stall_cycles", 128'(lat_cnt), 128'(e.lat));
          if (e.rd) chk("rdata", 128'(proc_rdata), 128'(e.rdata));
          if (!proc_read) chk("wr_rdata_zero", 128'(proc_rdata), '0);
          lat_cnt = 0;
        end
      end else begin
        chk("idle_out", 128'({proc_stall, proc_rdata}), '0);
      end
    end
  end

  // Memory responder: checks each request against the model and answers after mem_lat cycles.
  initial begin : responder
    mexp_t e;
    int    lat;
    int    n;
    bit    held;
    bit    aborted;
    bit    known;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n && (mem_read || mem_write)) begin
        lat = mem_lat; held = 1'b1; aborted = 1'b0; known = 1'b0;
        if (mem_q.size() == 0) begin
          total++; bad++;
          $display("FAIL mem_unexpected rd=%0b wr=%0b addr=%0h", mem_read, mem_write, mem_addr);
        end else begin
          e = mem_q.pop_front();
          known = 1'b1;
          chk("mem_kind", 128'({mem_write, mem_read}), 128'({e.wr, ~e.wr}));
          chk("mem_addr", 128'(mem_addr), 128'(e.addr));
          if (e.wr) chk("mem_wdata", mem_wdata, e.wdata);
        end
        n = 1;
        while (n < lat) begin
          @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          if (known) held &= (mem_read == !e.wr) && (mem_write == e.wr) && (mem_addr == e.addr)
                             && (!e.wr || mem_wdata == e.wdata);
          n++;
        end
        if (!aborted) begin
          if (known) chk("mem_hold", 128'(held), 128'(1));
          if (mem_read) mem_rdata = mem_get(1'b1, mem_addr);
          if (mem_write) phys_mem[mem_addr] = mem_wdata;
          mem_ready = 1'b1;
          @(posedge clk); #1;
          mem_ready = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst_n = 1'b0; proc_read = 1'b0; proc_write = 1'b0; proc_addr = '0; proc_wdata = '0;
    model_reset();
    ref_mem[28'h1]  = {32'hD, 32'hC, 32'hB, 32'hA};
    phys_mem[28'h1] = {32'hD, 32'hC, 32'hB, 32'hA};
    #1;
    proc_read = 1'b1; proc_addr = 30'h5;
    #1;
    chk("rst_stall", 128'(proc_stall), '0);
    chk("rst_rdata", 128'(proc_rdata), '0);
    chk("rst_mem_rw", 128'({mem_read, mem_write}), '0);
    chk("rst_mem_addr", 128'(mem_addr), '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    proc_read = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    mem_lat = 3;
    access(1'b0, 1'b1, 30'h5, '0);           // cold miss, word B
    access(1'b0, 1'b1, 30'h4, '0);           // hit A
    access(1'b0, 1'b1, 30'h7, '0);           // hit D
    access(1'b1, 1'b0, 30'h5, 32'hCAFE);     // write hit
    access(1'b0, 1'b1, 30'h25, '0);          // dirty eviction of block 1
    access(1'b1, 1'b0, 30'h40, 32'h1234);    // write miss, clean line
    access(1'b0, 1'b1, 30'h60, '0);          // conflicting read evicts it

    mem_lat = 20;
    access(1'b1, 1'b0, 30'h25, 32'h5555);
    access(1'b0, 1'b1, 30'h5, '0);           // slow write-back plus slow fill

    reset_mid(30'h87);
    mem_lat = 2;
    access(1'b0, 1'b1, 30'h87, '0);          // misses again after reset

    for (int i = 0; i < 300; i++) begin
      logic [29:0] a;
      bit          w;
      bit          r;
      a = {25'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      mem_lat = int'($urandom_range(1, 4));
      w = ($urandom_range(0, 2) == 0);
      r = !w || ($urandom_range(0, 7) == 0);
      access(w, r, a, $urandom);
    end

    repeat (5) @(negedge clk);
    chk("exp_q_drained", 128'(exp_q.size()), '0);
    chk("mem_q_drained", 128'(mem_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
